// File: rtl/tile_pkg.sv
// Shared tile-map definitions: command encodings, map geometry, glyph codes.
package tile_pkg;

  // Command opcodes on cmd_op
  typedef enum logic [1:0] {
    OP_WRITE    = 2'b00,
    OP_TEST_SET = 2'b01,
    OP_CLEAR    = 2'b10,
    OP_NOP      = 2'b11
  } op_e;

  // Tile-map geometry (one 16-bit word per 4x4-pixel tile)
  localparam int unsigned TILE_BASE = 40000;
  localparam int unsigned TILE_COLS = 160;
  localparam int unsigned TILE_ROWS = 120;
  localparam int unsigned TILE_X_W  = 8;
  localparam int unsigned TILE_Y_W  = 7;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned GLYPH_W   = 16;

  // Glyph codes shared with the pixel generator
  localparam logic [GLYPH_W-1:0] GLYPH_BLACK      = 16'd0;
  localparam logic [GLYPH_W-1:0] GLYPH_BLUE_SQ    = 16'd1;
  localparam logic [GLYPH_W-1:0] GLYPH_YELLOW_SQ  = 16'd2;
  localparam logic [GLYPH_W-1:0] GLYPH_PATH_FIRST = 16'd4;
  localparam logic [GLYPH_W-1:0] GLYPH_BIKE_LAST  = 16'd59;

  // Command payload as seen on the valid/ready port
  typedef struct packed {
    op_e                 op;
    logic [TILE_X_W-1:0] x;
    logic [TILE_Y_W-1:0] y;
    logic [GLYPH_W-1:0]  glyph;
  } tile_cmd_t;

  // Writer sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CHK  = 2'd2,
    ST_CLR  = 2'd3
  } tw_state_e;

endpackage

// File: rtl/tile_addr_calc.sv
// Combinational tile (x,y) -> RAM word address, plus map bounds check.
module tile_addr_calc
  import tile_pkg::*;
#(
  parameter int unsigned BASE_ADDR = TILE_BASE,
  parameter int unsigned COLS      = TILE_COLS,
  parameter int unsigned ROWS      = TILE_ROWS
) (
  input  logic [TILE_X_W-1:0] x,
  input  logic [TILE_Y_W-1:0] y,
  output logic [ADDR_W-1:0]   addr,
  output logic                in_range
);

  logic [ADDR_W-1:0] row_off;

  // Row offset uses the shift-add form for the native 160-wide map
  always_comb begin
    if (COLS == 32'd160) begin
      row_off = (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5);
    end else begin
      row_off = ADDR_W'(32'(y) * COLS);
    end
    addr     = ADDR_W'(BASE_ADDR) + row_off + ADDR_W'(x);
    in_range = (32'(x) < COLS) && (32'(y) < ROWS);
  end

endmodule

// File: rtl/tile_writer.sv
// Tile-map RAM writer: single writes, test-and-set writes, full-map clear.
module tile_writer
  import tile_pkg::*;
#(
  parameter int unsigned        BASE_ADDR   = TILE_BASE,
  parameter int unsigned        COLS        = TILE_COLS,
  parameter int unsigned        ROWS        = TILE_ROWS,
  parameter logic [GLYPH_W-1:0] CLEAR_GLYPH = GLYPH_BLACK
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [TILE_X_W-1:0] cmd_x,
  input  logic [TILE_Y_W-1:0] cmd_y,
  input  logic [GLYPH_W-1:0]  cmd_glyph,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_we,
  output logic [GLYPH_W-1:0]  mem_wdata,
  output logic                mem_re,
  input  logic [GLYPH_W-1:0]  mem_rdata,
  output logic                busy,
  output logic                done,
  output logic                collision,
  output logic                range_err
);

  localparam int unsigned         CNT_W     = 15;
  localparam int unsigned         MAP_TILES = COLS * ROWS;
  localparam logic [CNT_W-1:0]    LAST_IDX  = CNT_W'(MAP_TILES - 1);

  tw_state_e          state;
  tile_cmd_t          cmd;
  logic [GLYPH_W-1:0] glyph_q;
  logic [CNT_W-1:0]   clr_idx;
  logic [ADDR_W-1:0]  calc_addr;
  logic               calc_in_range;
  logic               accept;

  // Bundle the command port fields
  assign cmd = '{op: op_e'(cmd_op), x: cmd_x, y: cmd_y, glyph: cmd_glyph};

  // Handshake and status are direct decodes of the state register
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  tile_addr_calc #(
    .BASE_ADDR (BASE_ADDR),
    .COLS      (COLS),
    .ROWS      (ROWS)
  ) u_addr_calc (
    .x        (cmd.x),
    .y        (cmd.y),
    .addr     (calc_addr),
    .in_range (calc_in_range)
  );

  // Command sequencer with registered RAM strobes and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      done      <= 1'b0;
      collision <= 1'b0;
      range_err <= 1'b0;
      glyph_q   <= '0;
      clr_idx   <= '0;
    end else begin
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      done      <= 1'b0;
      collision <= 1'b0;
      range_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (cmd.op)
              OP_WRITE: begin
                done <= 1'b1;
                if (calc_in_range) begin
                  mem_addr  <= calc_addr;
                  mem_wdata <= cmd.glyph;
                  mem_we    <= 1'b1;
                end else begin
                  range_err <= 1'b1;
                end
              end
              OP_TEST_SET: begin
                if (calc_in_range) begin
                  mem_addr <= calc_addr;
                  mem_re   <= 1'b1;
                  glyph_q  <= cmd.glyph;
                  state    <= ST_RD;
                end else begin
                  range_err <= 1'b1;
                  done      <= 1'b1;
                end
              end
              OP_CLEAR: begin
                // Index 0 is issued at the accept edge; the counter tracks the next index
                mem_addr  <= ADDR_W'(BASE_ADDR);
                mem_wdata <= CLEAR_GLYPH;
                mem_we    <= 1'b1;
                clr_idx   <= CNT_W'(1);
                if (LAST_IDX == '0) begin
                  done <= 1'b1;
                end else begin
                  state <= ST_CLR;
                end
              end
              default: begin
                done <= 1'b1;
              end
            endcase
          end
        end
        ST_RD: begin
          state <= ST_CHK;
        end
        ST_CHK: begin
          // Read data from the RD-cycle request is valid now; mem_addr still points at the tile
          if (mem_rdata == CLEAR_GLYPH) begin
            mem_wdata <= glyph_q;
            mem_we    <= 1'b1;
          end else begin
            collision <= 1'b1;
          end
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        ST_CLR: begin
          mem_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(clr_idx);
          mem_wdata <= CLEAR_GLYPH;
          mem_we    <= 1'b1;
          clr_idx   <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) begin
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_writer.sv
// Directed bench for tile_writer with a sparse synchronous-read RAM model.
module tb_tile_writer;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [15:0] cmd_glyph;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        collision;
  logic        range_err;

  int checks;
  int failures;

  logic [15:0] ram [int unsigned];

  tile_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_glyph (cmd_glyph),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .collision (collision),
    .range_err (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: write on strobe, read data registered one cycle after mem_re
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= ram.exists(32'(mem_addr)) ? ram[32'(mem_addr)] : 16'd0;
    if (mem_we) ram[32'(mem_addr)] = mem_wdata;
  end

  function automatic logic [15:0] ram_rd(input int unsigned a);
    return ram.exists(a) ? ram[a] : 16'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] x,
                       input logic [6:0] y, input logic [15:0] g);
    cmd_valid = v;
    cmd_op    = op;
    cmd_x     = x;
    cmd_y     = y;
    cmd_glyph = g;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [15:0] glyph;
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic        rerr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int nw;
    int addr_bad;
    int rdy_bad;
    int done_cyc;
    bit found;

    checks   = 0;
    failures = 0;
    mem_rdata = 16'd0;

    // Single-cycle commands applied back-to-back, one per clock
    vecs[0] = '{2'b00,   8'd3,   7'd2, 16'd4,  1'b1, 1'b0, 16'd40323, 1'b0};
    vecs[1] = '{2'b00,   8'd0,   7'd0, 16'd1,  1'b1, 1'b0, 16'd40000, 1'b0};
    vecs[2] = '{2'b00, 8'd159, 7'd119, 16'd2,  1'b1, 1'b0, 16'd59199, 1'b0};
    vecs[3] = '{2'b00, 8'd160,   7'd0, 16'd7,  1'b0, 1'b0, 16'd0,     1'b1};
    vecs[4] = '{2'b00,   8'd0, 7'd120, 16'd7,  1'b0, 1'b0, 16'd0,     1'b1};
    vecs[5] = '{2'b11,   8'd5,   7'd5, 16'd9,  1'b0, 1'b0, 16'd0,     1'b0};
    vecs[6] = '{2'b00,  8'd17,  7'd33, 16'd59, 1'b1, 1'b0, 16'd45297, 1'b0};
    vecs[7] = '{2'b00, 8'd255, 7'd127, 16'd3,  1'b0, 1'b0, 16'd0,     1'b1};
    vecs[8] = '{2'b01, 8'd160,   7'd5, 16'd3,  1'b0, 1'b0, 16'd0,     1'b1};

    // Reset with a command pending: nothing may be accepted
    rst_n = 1'b0;
    drive(1'b1, 2'b00, 8'd3, 7'd2, 16'd4);
    #2;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    tick();
    tick();
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_re", 32'(mem_re), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_coll", 32'(collision), 32'd0);
    chk("rst_rerr", 32'(range_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_we", 32'(mem_we), 32'd0);

    // Table: each vector accepted on one edge and checked just after it
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].glyph);
      tick();
      chk($sformatf("vec%0d_we", i), 32'(mem_we), 32'(vecs[i].we));
      chk($sformatf("vec%0d_re", i), 32'(mem_re), 32'(vecs[i].re));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'd1);
      chk($sformatf("vec%0d_rerr", i), 32'(range_err), 32'(vecs[i].rerr));
      chk($sformatf("vec%0d_ready", i), 32'(cmd_ready), 32'd1);
      if (vecs[i].we) begin
        chk($sformatf("vec%0d_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
        chk($sformatf("vec%0d_wdata", i), 32'(mem_wdata), 32'(vecs[i].glyph));
      end
    end
    cmd_valid = 1'b0;
    tick();
    chk("post_tbl_done", 32'(done), 32'd0);
    chk("post_tbl_rerr", 32'(range_err), 32'd0);

    // TEST_SET on an empty tile: read, then write
    drive(1'b1, 2'b01, 8'd10, 7'd5, 16'd34);
    tick();
    cmd_valid = 1'b0;
    chk("ts1_p1_re", 32'(mem_re), 32'd1);
    chk("ts1_p1_addr", 32'(mem_addr), 32'd40810);
    chk("ts1_p1_we", 32'(mem_we), 32'd0);
    chk("ts1_p1_ready", 32'(cmd_ready), 32'd0);
    chk("ts1_p1_busy", 32'(busy), 32'd1);
    tick();
    chk("ts1_p2_re", 32'(mem_re), 32'd0);
    chk("ts1_p2_ready", 32'(cmd_ready), 32'd0);
    chk("ts1_p2_done", 32'(done), 32'd0);
    tick();
    chk("ts1_p3_we", 32'(mem_we), 32'd1);
    chk("ts1_p3_addr", 32'(mem_addr), 32'd40810);
    chk("ts1_p3_wdata", 32'(mem_wdata), 32'd34);
    chk("ts1_p3_done", 32'(done), 32'd1);
    chk("ts1_p3_coll", 32'(collision), 32'd0);
    chk("ts1_p3_ready", 32'(cmd_ready), 32'd1);
    tick();
    chk("ts1_p4_done", 32'(done), 32'd0);
    chk("ts1_ram", 32'(ram_rd(40810)), 32'd34);

    // TEST_SET on the now-occupied tile, with a WRITE held during busy
    drive(1'b1, 2'b01, 8'd10, 7'd5, 16'd34);
    tick();
    drive(1'b1, 2'b00, 8'd1, 7'd1, 16'd9);
    chk("ts2_p1_re", 32'(mem_re), 32'd1);
    tick();
    chk("ts2_p2_we", 32'(mem_we), 32'd0);
    tick();
    chk("ts2_p3_we", 32'(mem_we), 32'd0);
    chk("ts2_p3_coll", 32'(collision), 32'd1);
    chk("ts2_p3_done", 32'(done), 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("held_we", 32'(mem_we), 32'd1);
    chk("held_addr", 32'(mem_addr), 32'd40161);
    chk("held_wdata", 32'(mem_wdata), 32'd9);
    chk("ts2_p4_coll", 32'(collision), 32'd0);
    tick();
    chk("held_once", 32'(mem_we), 32'd0);

    // Full clear: 19200 ascending writes of 0, done on the last one
    drive(1'b1, 2'b10, 8'd200, 7'd100, 16'd77);
    tick();
    cmd_valid = 1'b0;
    nw = 0; addr_bad = 0; rdy_bad = 0; done_cyc = -1;
    for (int cyc = 1; cyc <= 20000; cyc++) begin
      if (mem_we) begin
        if (mem_addr !== 16'(40000 + nw) || mem_wdata !== 16'd0) addr_bad++;
        nw++;
      end
      if (!done && cmd_ready) rdy_bad++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      tick();
    end
    chk("clr_done_cycle", 32'(done_cyc), 32'd19200);
    chk("clr_writes", 32'(nw), 32'd19200);
    chk("clr_addr_data_errs", 32'(addr_bad), 32'd0);
    chk("clr_ready_errs", 32'(rdy_bad), 32'd0);
    chk("clr_last_we", 32'(mem_we), 32'd1);
    tick();
    chk("clr_after_we", 32'(mem_we), 32'd0);
    chk("clr_after_done", 32'(done), 32'd0);
    chk("clr_ram_first", 32'(ram_rd(40323)), 32'd0);
    chk("clr_ram_last", 32'(ram_rd(59199)), 32'd0);

    // Marker beyond index 5000 survives an aborted clear
    drive(1'b1, 2'b00, 8'd1, 7'd100, 16'd5);
    tick();
    cmd_valid = 1'b0;
    chk("mark_addr", 32'(mem_addr), 32'd56001);
    drive(1'b1, 2'b10, 8'd0, 7'd0, 16'd0);
    tick();
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (mem_we && mem_addr == 16'd45000) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("abort_reached_5000", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("abort_idle_we", 32'(mem_we), 32'd0);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    chk("abort_partial", 32'(ram_rd(56001)), 32'd5);
    drive(1'b1, 2'b00, 8'd5, 7'd5, 16'd3);
    tick();
    cmd_valid = 1'b0;
    chk("post_abort_we", 32'(mem_we), 32'd1);
    chk("post_abort_addr", 32'(mem_addr), 32'd40805);
    chk("post_abort_wdata", 32'(mem_wdata), 32'd3);
    chk("post_abort_done", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
